ascon_serial_sequencer: RTL and testbench
=========================================

// Module: ascon_serial_sequencer
// PURPOSE
//  Host-side controller for the bit-serial ASCON-128 core in the user project. Accepts one parallel
//  job (key, nonce, AD, data, direction), resets the core, shifts all operands in MSB-first, pulses
//  start, waits for core ready, and shifts result data and tag back out into parallel registers.
//  Replaces pin-level bit-banging from the harness; sits between the Wishbone register file and the core.
// PARAMETERS
//  AD_W      40    associated-data width in bits (1..128)
//  DATA_W    104   plaintext/ciphertext width in bits (1..128)
//  RST_CYC   2     cycles core_rst_o is held high before loading
//  START_CYC 3     cycles core_start_o is held high
//  READ_GAP  2     cycles between core_ready_i rising and first output-bit sample
//  TIMEOUT   4096  max cycles in WAIT before abort (only with ASCON_SEQ_TIMEOUT_EN)
// PORTS
//  clk            in   1       clock, all logic on rising edge
//  rst_n          in   1       async active-low reset
//  req_valid_i    in   1       job request
//  req_ready_o    out  1       high only in IDLE
//  req_decrypt_i  in   1       0 = encrypt, 1 = decrypt
//  req_key_i      in   128     key
//  req_nonce_i    in   128     nonce
//  req_ad_i       in   AD_W    associated data
//  req_data_i     in   DATA_W  plaintext (enc) / ciphertext (dec)
//  rsp_valid_o    out  1       result available; held until rsp_ready_i
//  rsp_ready_i    in   1       result consumed
//  rsp_data_o     out  DATA_W  ciphertext (enc) / plaintext (dec)
//  rsp_tag_o      out  128     tag
//  rsp_cycles_o   out  16      cycles from first start cycle to core_ready_i, saturating at 16'hFFFF
//  rsp_err_o      out  1       timeout abort (constant 0 without ASCON_SEQ_TIMEOUT_EN)
//  core_rst_o     out  1       core reset, active high
//  core_decrypt_o out  1       registered copy of req_decrypt_i
//  core_key_o, core_nonce_o, core_ad_o, core_data_o  out 1 each  serial operand bits
//  core_start_o   out  1       start strobe
//  core_ready_i   in   1       core done (level)
//  core_data_i    in   1       serial result data bit
//  core_tag_i     in   1       serial tag bit
// BEHAVIOUR
//  - Reset: state IDLE; req_ready_o=1; rsp_valid_o=0; rsp_data/tag/cycles/err=0; core_rst_o=1;
//    all core_* serial outputs, core_start_o, core_decrypt_o = 0. All outputs registered.
//  - LOAD_LEN = max(128, AD_W, DATA_W). States: IDLE->CRST->LOAD->START->WAIT->GAP->READ->DONE->IDLE.
//  - IDLE: core_rst_o=1. req_valid_i&&req_ready_o captures all operands + direction; ->CRST.
//  - CRST: core_rst_o=1 for RST_CYC cycles, then 0 from LOAD onward until next IDLE.
//  - LOAD: LOAD_LEN cycles, index i=0..LOAD_LEN-1: key bit 127-i, nonce bit 127-i, data bit DATA_W-1-i
//    (if i<DATA_W), AD bit AD_W-1-i (if i<AD_W); lines past their width hold last bit. ->START.
//  - START: core_start_o=1 exactly START_CYC cycles; cycle counter cleared at first START cycle.
//  - WAIT: core_ready_i sampled only here (ignored in all other states); high on first WAIT cycle
//    is accepted immediately. ->GAP latching rsp_cycles_o.
//  - GAP: READ_GAP idle cycles. READ: LOAD_LEN cycles; at index i, rsp_data_o[DATA_W-1-i]<=core_data_i
//    (i<DATA_W), rsp_tag_o[127-i]<=core_tag_i (i<128). ->DONE.
//  - DONE: rsp_valid_o=1; on rsp_ready_i ->IDLE (rsp_valid_o drops next cycle, fields retained).
//    req_valid_i while not IDLE is ignored (no queueing).
//  - rst_n low in any state: immediate return to reset values; partial job discarded.
// CONFIGURATION
//  ASCON_SEQ_TIMEOUT_EN defined: WAIT longer than TIMEOUT cycles -> DONE with rsp_err_o=1,
//  rsp_data_o/rsp_tag_o=0, rsp_cycles_o=TIMEOUT. Undefined: WAIT indefinitely; rsp_err_o tied 0.
// STRUCTURE
//  Package ascon_seq_pkg: state enum, KEY_W=128, TAG_W=128, CNT_W=16, load_len() function.
//  Sub-module ascon_seq_shifter: parallel-load/serial-out operand shifters plus serial-in result
//  shifters with bit index counter; FSM and cycle counter live in the top.
// TESTING
//  1 Enc: key 6d4f8bbf60ec05a07b201d4e5b2119ac, nonce 05885e606e1271b8d47a74c7b297a318,
//    AD 4153434f4e, PT 6173636f6e2d756e6963617373 -> rsp_data_o=18490112f8d5867a830748390b, err=0.
//  2 Dec same key/nonce/AD, data=18490112f8d5867a830748390b -> rsp_data_o=6173636f6e2d756e6963617373,
//    rsp_tag_o equal to test 1 tag.
//  3 Core model: ready 37 cycles after last start -> rsp_cycles_o=40; core_start_o high exactly 3 cycles.
//  4 rst_n low mid-LOAD (i=50) -> next cycle all outputs at reset values; following job completes OK.
//  5 req_valid_i held during job and rsp_ready_i low 10 cycles in DONE -> single job, rsp held stable.
//  6 TIMEOUT_EN, TIMEOUT=64, core_ready_i stuck 0 -> rsp_err_o=1, rsp_cycles_o=64, back to IDLE.

Source files
------------

// File: rtl/ascon_seq_pkg.sv
// ascon_seq_pkg: shared widths, FSM state codes and load-length helper for the ASCON serial sequencer
package ascon_seq_pkg;
  localparam int KEY_W = 128;
  localparam int TAG_W = 128;
  localparam int CNT_W = 16;
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_CRST  = 3'd1;
  localparam state_t S_LOAD  = 3'd2;
  localparam state_t S_START = 3'd3;
  localparam state_t S_WAIT  = 3'd4;
  localparam state_t S_GAP   = 3'd5;
  localparam state_t S_READ  = 3'd6;
  localparam state_t S_DONE  = 3'd7;
  function automatic int load_len(input int ad_w, input int data_w);
    int m;
    m = KEY_W;
    if (ad_w > m) m = ad_w;
    if (data_w > m) m = data_w;
    return m;
  endfunction
endpackage

// File: rtl/ascon_seq_shifter.sv
// ascon_seq_shifter: parallel-in/serial-out operand shifters and serial-in result shifters with bit index
module ascon_seq_shifter
  import ascon_seq_pkg::*;
#(
  parameter int AD_W   = 40,
  parameter int DATA_W = 104
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_shift_out,
  input  logic              i_shift_in,
  input  logic              i_clr,
  input  logic [KEY_W-1:0]  i_key,
  input  logic [KEY_W-1:0]  i_nonce,
  input  logic [AD_W-1:0]   i_ad,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_data_bit,
  input  logic              i_tag_bit,
  output logic              o_key,
  output logic              o_nonce,
  output logic              o_ad,
  output logic              o_data,
  output logic              o_last,
  output logic [DATA_W-1:0] o_rsp_data,
  output logic [TAG_W-1:0]  o_rsp_tag
);
  localparam logic [7:0] LAST = 8'(load_len(AD_W, DATA_W) - 1);
  localparam logic [7:0] DW = 8'(DATA_W);
  logic [KEY_W-1:0] r_key, r_nonce;
  logic [AD_W-1:0] r_ad;
  logic [DATA_W-1:0] r_data, r_rsp_data;
  logic [TAG_W-1:0] r_rsp_tag;
  logic [7:0] r_idx;
  // operand lines shift left replicating bit 0, so a short line holds its last bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key <= '0;
      r_nonce <= '0;
      r_ad <= '0;
      r_data <= '0;
      r_rsp_data <= '0;
      r_rsp_tag <= '0;
      r_idx <= '0;
    end else begin
      r_idx <= (i_shift_out || i_shift_in) ? r_idx + 8'd1 : 8'd0;
      if (i_load) begin
        r_key <= i_key;
        r_nonce <= i_nonce;
        r_ad <= i_ad;
        r_data <= i_data;
      end else if (i_shift_out) begin
        r_key <= (r_key << 1) | KEY_W'(r_key[0]);
        r_nonce <= (r_nonce << 1) | KEY_W'(r_nonce[0]);
        r_ad <= (r_ad << 1) | AD_W'(r_ad[0]);
        r_data <= (r_data << 1) | DATA_W'(r_data[0]);
      end
      if (i_clr) begin
        r_rsp_data <= '0;
        r_rsp_tag <= '0;
      end else if (i_shift_in) begin
        if (r_idx < DW) r_rsp_data <= (r_rsp_data << 1) | DATA_W'(i_data_bit);
        r_rsp_tag <= (r_rsp_tag << 1) | TAG_W'(i_tag_bit);
      end
    end
  end
  assign o_key = r_key[KEY_W-1];
  assign o_nonce = r_nonce[KEY_W-1];
  assign o_ad = r_ad[AD_W-1];
  assign o_data = r_data[DATA_W-1];
  assign o_last = r_idx == LAST;
  assign o_rsp_data = r_rsp_data;
  assign o_rsp_tag = r_rsp_tag;
endmodule

// File: rtl/ascon_serial_sequencer.sv
// ascon_serial_sequencer: job FSM driving the bit-serial ASCON core; ASCON_SEQ_TIMEOUT_EN enables WAIT abort
module ascon_serial_sequencer
  import ascon_seq_pkg::*;
#(
  parameter int AD_W      = 40,
  parameter int DATA_W    = 104,
  parameter int RST_CYC   = 2,
  parameter int START_CYC = 3,
  parameter int READ_GAP  = 2,
  parameter int TIMEOUT   = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_decrypt_i,
  input  logic [KEY_W-1:0]  req_key_i,
  input  logic [KEY_W-1:0]  req_nonce_i,
  input  logic [AD_W-1:0]   req_ad_i,
  input  logic [DATA_W-1:0] req_data_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic [TAG_W-1:0]  rsp_tag_o,
  output logic [CNT_W-1:0]  rsp_cycles_o,
  output logic              rsp_err_o,
  output logic              core_rst_o,
  output logic              core_decrypt_o,
  output logic              core_key_o,
  output logic              core_nonce_o,
  output logic              core_ad_o,
  output logic              core_data_o,
  output logic              core_start_o,
  input  logic              core_ready_i,
  input  logic              core_data_i,
  input  logic              core_tag_i
);
  localparam logic [CNT_W-1:0] TMO_CYC = CNT_W'(TIMEOUT);
  state_t r_state, w_nxt;
  logic [CNT_W-1:0] r_cnt, r_cyc, r_rsp_cyc, w_cyc_inc;
  logic r_req_ready, r_rsp_valid, r_err, r_core_rst, r_start, r_dec;
  logic w_acc, w_last, w_tmo, w_rdy;
  assign w_acc = r_state == S_IDLE && req_valid_i;
  assign w_rdy = r_state == S_WAIT && core_ready_i;
  assign w_cyc_inc = &r_cyc ? r_cyc : r_cyc + CNT_W'(1);
`ifdef ASCON_SEQ_TIMEOUT_EN
  assign w_tmo = r_state == S_WAIT && !core_ready_i && r_cnt == TMO_CYC - CNT_W'(1);
`else
  assign w_tmo = 1'b0;
`endif
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:  w_nxt = req_valid_i ? S_CRST : S_IDLE;
      S_CRST:  w_nxt = r_cnt == CNT_W'(RST_CYC - 1) ? S_LOAD : S_CRST;
      S_LOAD:  w_nxt = w_last ? S_START : S_LOAD;
      S_START: w_nxt = r_cnt == CNT_W'(START_CYC - 1) ? S_WAIT : S_START;
      S_WAIT:  w_nxt = core_ready_i ? S_GAP : w_tmo ? S_DONE : S_WAIT;
      S_GAP:   w_nxt = r_cnt == CNT_W'(READ_GAP - 1) ? S_READ : S_GAP;
      S_READ:  w_nxt = w_last ? S_DONE : S_READ;
      S_DONE:  w_nxt = rsp_ready_i ? S_IDLE : S_DONE;
    endcase
  end
  // outputs decode the next state so they line up with the state they describe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt <= '0;
      r_cyc <= '0;
      r_rsp_cyc <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_err <= 1'b0;
      r_core_rst <= 1'b1;
      r_start <= 1'b0;
      r_dec <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_cnt <= w_nxt != r_state ? '0 : r_cnt + CNT_W'(1);
      r_cyc <= (w_nxt == S_START && r_state != S_START) ? '0 : w_cyc_inc;
      r_req_ready <= w_nxt == S_IDLE;
      r_rsp_valid <= w_nxt == S_DONE;
      r_core_rst <= w_nxt == S_IDLE || w_nxt == S_CRST;
      r_start <= w_nxt == S_START;
      if (w_acc) begin
        r_dec <= req_decrypt_i;
        r_err <= 1'b0;
      end
      if (w_rdy) r_rsp_cyc <= w_cyc_inc;
      else if (w_tmo) begin
        r_rsp_cyc <= TMO_CYC;
        r_err <= 1'b1;
      end
    end
  end
  ascon_seq_shifter #(.AD_W(AD_W), .DATA_W(DATA_W)) u_shf (
    .clk(clk),
    .rst_n(rst_n),
    .i_load(w_acc),
    .i_shift_out(r_state == S_LOAD),
    .i_shift_in(r_state == S_READ),
    .i_clr(w_tmo),
    .i_key(req_key_i),
    .i_nonce(req_nonce_i),
    .i_ad(req_ad_i),
    .i_data(req_data_i),
    .i_data_bit(core_data_i),
    .i_tag_bit(core_tag_i),
    .o_key(core_key_o),
    .o_nonce(core_nonce_o),
    .o_ad(core_ad_o),
    .o_data(core_data_o),
    .o_last(w_last),
    .o_rsp_data(rsp_data_o),
    .o_rsp_tag(rsp_tag_o)
  );
  assign req_ready_o = r_req_ready;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_cycles_o = r_rsp_cyc;
  assign rsp_err_o = r_err;
  assign core_rst_o = r_core_rst;
  assign core_start_o = r_start;
  assign core_decrypt_o = r_dec;
endmodule

// File: tb/tb_ascon_serial_sequencer.sv
// tb_ascon_serial_sequencer: directed jobs against a cycle-timed core model with hand-computed results
module tb_ascon_serial_sequencer;
  localparam int AD_W = 40;
  localparam int DATA_W = 104;
`ifdef ASCON_SEQ_TIMEOUT_EN
  localparam int TMO = 64;
`else
  localparam int TMO = 4096;
`endif
  localparam logic [127:0] KEY = 128'h6d4f8bbf60ec05a07b201d4e5b2119ac;
  localparam logic [127:0] NONCE = 128'h05885e606e1271b8d47a74c7b297a318;
  localparam logic [AD_W-1:0] AD = 40'h4153434f4e;
  localparam logic [DATA_W-1:0] PT = 104'h6173636f6e2d756e6963617373;
  localparam logic [DATA_W-1:0] CT = 104'h18490112f8d5867a830748390b;
  localparam logic [127:0] TAG = 128'hc4b5a2d10e9f8a7b3c6d5e4f11223344;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid_i = 0, req_decrypt_i = 0, rsp_ready_i = 0;
  logic [127:0] req_key_i = '0, req_nonce_i = '0;
  logic [AD_W-1:0] req_ad_i = '0;
  logic [DATA_W-1:0] req_data_i = '0;
  logic core_ready_i = 0, core_data_i = 0, core_tag_i = 0;
  logic req_ready_o, rsp_valid_o, rsp_err_o, core_rst_o, core_decrypt_o;
  logic core_key_o, core_nonce_o, core_ad_o, core_data_o, core_start_o;
  logic [DATA_W-1:0] rsp_data_o;
  logic [127:0] rsp_tag_o;
  logic [15:0] rsp_cycles_o;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  ascon_serial_sequencer #(.AD_W(AD_W), .DATA_W(DATA_W), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_decrypt_i(req_decrypt_i),
    .req_key_i(req_key_i), .req_nonce_i(req_nonce_i), .req_ad_i(req_ad_i), .req_data_i(req_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
    .rsp_tag_o(rsp_tag_o), .rsp_cycles_o(rsp_cycles_o), .rsp_err_o(rsp_err_o),
    .core_rst_o(core_rst_o), .core_decrypt_o(core_decrypt_o), .core_key_o(core_key_o),
    .core_nonce_o(core_nonce_o), .core_ad_o(core_ad_o), .core_data_o(core_data_o),
    .core_start_o(core_start_o), .core_ready_i(core_ready_i), .core_data_i(core_data_i),
    .core_tag_i(core_tag_i)
  );
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_reset_vals(input string nm);
    chk({nm, "_req_ready"}, req_ready_o, 1);
    chk({nm, "_rsp_valid"}, rsp_valid_o, 0);
    chk({nm, "_core_rst"}, core_rst_o, 1);
    chk({nm, "_core_lines"}, {core_key_o, core_nonce_o, core_ad_o, core_data_o, core_start_o, core_decrypt_o}, 0);
    chk({nm, "_rsp_fields"}, {rsp_data_o, rsp_cycles_o, rsp_err_o}, 0);
    chk({nm, "_rsp_tag"}, rsp_tag_o, 0);
  endtask
  task automatic issue(input logic dec, input logic [DATA_W-1:0] din);
    req_decrypt_i = dec;
    req_key_i = KEY;
    req_nonce_i = NONCE;
    req_ad_i = AD;
    req_data_i = din;
    req_valid_i = 1;
    step;
  endtask
  task automatic do_job(input string nm, input logic dec, input logic [DATA_W-1:0] din,
                        input logic [DATA_W-1:0] dout, input int lat, input bit hold);
    logic [127:0] k, n, t;
    logic [AD_W-1:0] a;
    logic [DATA_W-1:0] d;
    int c;
    bit stable;
    issue(dec, din);
    chk({nm, "_accept"}, req_ready_o, 0);
    if (!hold) req_valid_i = 0;
    req_key_i = ~KEY;
    req_data_i = ~din;
    c = 0;
    while (core_rst_o && c < 20) begin c++; step; end
    chk({nm, "_rst_cycles"}, c, 2);
    k = '0; n = '0; a = '0; d = '0;
    for (int i = 0; i < 128; i++) begin
      k = {k[126:0], core_key_o};
      n = {n[126:0], core_nonce_o};
      if (i < AD_W) a = {a[AD_W-2:0], core_ad_o};
      if (i < DATA_W) d = {d[DATA_W-2:0], core_data_o};
      if (i == 127) chk({nm, "_hold_last"}, {core_ad_o, core_data_o}, {AD[0], din[0]});
      step;
    end
    chk({nm, "_key"}, k, KEY);
    chk({nm, "_nonce"}, n, NONCE);
    chk({nm, "_ad"}, a, AD);
    chk({nm, "_data_in"}, d, din);
    chk({nm, "_decrypt"}, core_decrypt_o, dec);
    c = 0;
    while (core_start_o && c < 10) begin c++; step; end
    chk({nm, "_start_cycles"}, c, 3);
    repeat (lat - 1) step;
    core_ready_i = 1;
    repeat (3) step;
    d = dout;
    t = TAG;
    for (int i = 0; i < 128; i++) begin
      core_data_i = (i < DATA_W) ? d[DATA_W-1] : 1'b0;
      core_tag_i = t[127];
      d = d << 1;
      t = t << 1;
      step;
    end
    core_ready_i = 0; core_data_i = 0; core_tag_i = 0;
    chk({nm, "_rsp_valid"}, rsp_valid_o, 1);
    chk({nm, "_rsp_data"}, rsp_data_o, dout);
    chk({nm, "_rsp_tag"}, rsp_tag_o, TAG);
    chk({nm, "_rsp_cycles"}, rsp_cycles_o, 3 + lat);
    chk({nm, "_rsp_err"}, rsp_err_o, 0);
    if (hold) begin
      stable = 1;
      repeat (10) begin
        stable &= rsp_valid_o && !req_ready_o && rsp_data_o == dout && rsp_tag_o == TAG;
        step;
      end
      chk({nm, "_held"}, stable, 1);
    end
    rsp_ready_i = 1;
    req_valid_i = 0;
    step;
    rsp_ready_i = 0;
    chk({nm, "_valid_drop"}, {rsp_valid_o, req_ready_o}, 2'b01);
    chk({nm, "_retained"}, rsp_data_o, dout);
    repeat (3) step;
    chk({nm, "_stay_idle"}, {core_rst_o, req_ready_o}, 2'b11);
  endtask
  initial begin
    int c;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst_n = 1;
    step;
    do_job("enc", 0, PT, CT, 37, 0);
    do_job("dec", 1, CT, PT, 5, 0);
    issue(1, PT);
    req_valid_i = 0;
    c = 0;
    while (core_rst_o && c < 20) begin c++; step; end
    repeat (50) step;
    rst_n = 0;
    step;
    chk_reset_vals("midload");
    rst_n = 1;
    step;
    do_job("post", 0, PT, CT, 1, 0);
    do_job("hold", 0, PT, CT, 10, 1);
`ifdef ASCON_SEQ_TIMEOUT_EN
    issue(0, PT);
    req_valid_i = 0;
    c = 0;
    while (!rsp_valid_o && c < 1000) begin c++; step; end
    chk("tmo_valid", rsp_valid_o, 1);
    chk("tmo_err", rsp_err_o, 1);
    chk("tmo_cycles", rsp_cycles_o, 64);
    chk("tmo_clear", {rsp_data_o, rsp_tag_o}, 0);
    rsp_ready_i = 1;
    step;
    rsp_ready_i = 0;
    chk("tmo_idle", {rsp_valid_o, req_ready_o}, 2'b01);
`else
    do_job("long", 1, CT, PT, 300, 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
